// File: rtl/timer_pkg.sv
// Shared types and defaults for the crossword stopwatch run-control block.
package timer_pkg;

    localparam int unsigned BCD_W = 16;
    localparam logic [BCD_W-1:0] DEFAULT_LIMIT_BCD = 16'h1000;
    localparam int unsigned DEFAULT_DEBOUNCE = 500000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        SOLVED  = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Raw push-key conditioning: two-flop synchronizer, stability counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw_i,
    output logic event_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic            event_q, event_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        event_d = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            event_q      <= 1'b0;
        end else begin
            sync1_q      <= key_raw_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            event_q      <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/puzzle_timer_ctrl.sv
// Run-control FSM for the crossword stopwatch: key events, solve/limit stop,
// and best-solve-time capture for the display mux.
module puzzle_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic [BCD_W-1:0]  LIMIT_BCD       = DEFAULT_LIMIT_BCD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_key,
    input  logic             pause_key,
    input  logic             solved,
    input  logic [BCD_W-1:0] time_bcd,
    output logic             sw_run,
    output logic             sw_reset,
    output logic [2:0]       state_o,
    output logic             timed_out,
    output logic             best_valid,
    output logic [BCD_W-1:0] best_bcd
);

    logic start_ev, pause_ev;
    logic limit_hit;
    logic solve_now;

    state_t           state_q, state_d;
    logic             sw_reset_q;
    logic             best_valid_q, best_valid_d;
    logic [BCD_W-1:0] best_bcd_q, best_bcd_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_key (
        .clk      (clk),
        .reset    (reset),
        .key_raw_i(start_key),
        .event_o  (start_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pause_key (
        .clk      (clk),
        .reset    (reset),
        .key_raw_i(pause_key),
        .event_o  (pause_ev)
    );

    // Packed BCD orders digits MSB to LSB, so plain unsigned compare is valid.
    assign limit_hit = (LIMIT_BCD != '0) && (time_bcd >= LIMIT_BCD);
    assign solve_now = (state_q == RUN) && solved;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sw_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered decode keeps the stopwatch's async clear glitch-free.
            sw_reset_q <= (state_d == CLEAR);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ev) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if (solved)         state_d = SOLVED;
                else if (limit_hit) state_d = TIMEOUT;
                else if (start_ev)  state_d = CLEAR;
                else if (pause_ev)  state_d = PAUSE;
            end
            PAUSE: begin
                if (start_ev)      state_d = CLEAR;
                else if (pause_ev) state_d = RUN;
            end
            SOLVED, TIMEOUT: begin
                if (start_ev) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sw_run    = (state_q == RUN);
        timed_out = (state_q == TIMEOUT);
        state_o   = state_q;
        sw_reset  = sw_reset_q;
    end

    always_comb begin
        best_valid_d = best_valid_q;
        best_bcd_d   = best_bcd_q;
        if (solve_now && (!best_valid_q || (time_bcd < best_bcd_q))) begin
            best_valid_d = 1'b1;
            best_bcd_d   = time_bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_valid_q <= 1'b0;
            best_bcd_q   <= '0;
        end else begin
            best_valid_q <= best_valid_d;
            best_bcd_q   <= best_bcd_d;
        end
    end

    assign best_valid = best_valid_q;
    assign best_bcd   = best_bcd_q;

endmodule

// File: tb/tb_puzzle_timer_ctrl.sv
// Directed bench for puzzle_timer_ctrl with a short debounce window.
module tb_puzzle_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_key;
    logic        pause_key;
    logic        solved;
    logic [15:0] time_bcd;
    logic        sw_run;
    logic        sw_reset;
    logic [2:0]  state_o;
    logic        timed_out;
    logic        best_valid;
    logic [15:0] best_bcd;

    int checks   = 0;
    int failures = 0;
    int rst_pulses = 0;
    int ev_cnt     = 0;

    always #5 clk = ~clk;

    puzzle_timer_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LIMIT_BCD      (16'h1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_key (start_key),
        .pause_key (pause_key),
        .solved    (solved),
        .time_bcd  (time_bcd),
        .sw_run    (sw_run),
        .sw_reset  (sw_reset),
        .state_o   (state_o),
        .timed_out (timed_out),
        .best_valid(best_valid),
        .best_bcd  (best_bcd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the falling edge; tally pulses seen.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (sw_reset === 1'b1) rst_pulses++;
        if (dut.start_ev === 1'b1) ev_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic s, input logic p);
        start_key = s;
        pause_key = p;
        ticks(9);
        start_key = 1'b0;
        pause_key = 1'b0;
        ticks(10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start_key = 1'b0;
        pause_key = 1'b0;
        solved    = 1'b0;
        time_bcd  = 16'h0000;
        @(negedge clk);
        ticks(2);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_sw_run", 32'(sw_run), 32'd0);
        check("rst_sw_reset", 32'(sw_reset), 32'd0);
        check("rst_timed_out", 32'(timed_out), 32'd0);
        check("rst_best_valid", 32'(best_valid), 32'd0);
        check("rst_best_bcd", 32'(best_bcd), 32'h0000);
        reset = 1'b0;

        // Held start key: one event seven cycles after the rise.
        rst_pulses = 0;
        ev_cnt     = 0;
        start_key  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 6) check("hold_no_ev_k6", 32'(dut.start_ev), 32'd0);
            if (k == 7) check("hold_ev_k7", 32'(dut.start_ev), 32'd1);
            if (k == 8) begin
                check("hold_clear_state", 32'(state_o), 32'd1);
                check("hold_sw_reset_hi", 32'(sw_reset), 32'd1);
            end
            if (k == 9) begin
                check("hold_run_state", 32'(state_o), 32'd2);
                check("hold_run_sw_run", 32'(sw_run), 32'd1);
                check("hold_sw_reset_lo", 32'(sw_reset), 32'd0);
            end
        end
        start_key = 1'b0;
        ticks(10);
        check("hold_one_event", 32'(ev_cnt), 32'd1);
        check("hold_one_sw_reset", 32'(rst_pulses), 32'd1);
        check("hold_still_run", 32'(state_o), 32'd2);

        // Bouncing key never stays stable long enough.
        do_reset();
        rst_pulses = 0;
        ev_cnt     = 0;
        for (int i = 0; i < 15; i++) begin
            start_key = ~start_key;
            ticks(2);
        end
        start_key = 1'b0;
        ticks(10);
        check("bounce_no_event", 32'(ev_cnt), 32'd0);
        check("bounce_no_sw_reset", 32'(rst_pulses), 32'd0);
        check("bounce_idle", 32'(state_o), 32'd0);

        // Limit: timeout at 10:00, and solve taking priority over timeout.
        do_reset();
        press(1'b1, 1'b0);
        check("lim_run", 32'(state_o), 32'd2);
        time_bcd = 16'h0959;
        tick();
        check("lim_below", 32'(state_o), 32'd2);
        time_bcd = 16'h1000;
        tick();
        check("lim_timeout_state", 32'(state_o), 32'd5);
        check("lim_timed_out", 32'(timed_out), 32'd1);
        check("lim_sw_run", 32'(sw_run), 32'd0);
        time_bcd = 16'h0000;
        press(1'b1, 1'b0);
        check("lim_restart_run", 32'(state_o), 32'd2);
        check("lim_restart_tout", 32'(timed_out), 32'd0);
        time_bcd = 16'h0959;
        tick();
        time_bcd = 16'h1000;
        solved   = 1'b1;
        tick();
        check("lim_solve_wins", 32'(state_o), 32'd4);
        check("lim_best_bcd", 32'(best_bcd), 32'h1000);
        solved   = 1'b0;
        time_bcd = 16'h0000;

        // Three solves: best keeps the fastest.
        do_reset();
        check("solve_best_cleared", 32'(best_valid), 32'd0);
        press(1'b1, 1'b0);
        time_bcd = 16'h0104;
        solved   = 1'b1;
        tick();
        check("solve1_state", 32'(state_o), 32'd4);
        check("solve1_sw_run", 32'(sw_run), 32'd0);
        check("solve1_best", 32'(best_bcd), 32'h0104);
        check("solve1_valid", 32'(best_valid), 32'd1);
        solved   = 1'b0;
        time_bcd = 16'h0000;
        press(1'b1, 1'b0);
        check("solve2_run", 32'(state_o), 32'd2);
        time_bcd = 16'h0230;
        solved   = 1'b1;
        tick();
        check("solve2_state", 32'(state_o), 32'd4);
        check("solve2_best_kept", 32'(best_bcd), 32'h0104);
        solved   = 1'b0;
        time_bcd = 16'h0000;
        press(1'b1, 1'b0);
        time_bcd = 16'h0059;
        solved   = 1'b1;
        tick();
        check("solve3_best", 32'(best_bcd), 32'h0059);
        solved   = 1'b0;
        time_bcd = 16'h0000;

        // Pause / resume, and start winning over a simultaneous pause.
        press(1'b1, 1'b0);
        check("pause_pre_run", 32'(state_o), 32'd2);
        press(1'b0, 1'b1);
        check("pause_state", 32'(state_o), 32'd3);
        check("pause_sw_run", 32'(sw_run), 32'd0);
        solved = 1'b1;
        ticks(3);
        check("pause_ignores_solved", 32'(state_o), 32'd3);
        solved = 1'b0;
        press(1'b0, 1'b1);
        check("resume_run", 32'(state_o), 32'd2);
        press(1'b0, 1'b1);
        check("pause_again", 32'(state_o), 32'd3);
        start_key = 1'b1;
        pause_key = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 8) begin
                check("both_clear", 32'(state_o), 32'd1);
                check("both_sw_reset", 32'(sw_reset), 32'd1);
            end
            if (k == 9) check("both_run", 32'(state_o), 32'd2);
        end
        start_key = 1'b0;
        pause_key = 1'b0;
        ticks(10);
        check("both_settled_run", 32'(state_o), 32'd2);

        // Mid-run reset clears everything, including the best time.
        reset = 1'b1;
        tick();
        check("mrst_state", 32'(state_o), 32'd0);
        check("mrst_sw_run", 32'(sw_run), 32'd0);
        check("mrst_sw_reset", 32'(sw_reset), 32'd0);
        check("mrst_timed_out", 32'(timed_out), 32'd0);
        check("mrst_best_valid", 32'(best_valid), 32'd0);
        check("mrst_best_bcd", 32'(best_bcd), 32'h0000);
        reset = 1'b0;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/puzzle_timer_ctrl.md
Name: puzzle_timer_ctrl

Overview:
- Run-control FSM for the crossword stopwatch datapath; drives the stopwatch's run and reset inputs.
- Turns the raw start and pause push-keys into clean one-cycle events.
- Stops timing when the puzzle is solved or the time limit is hit, and keeps the best solve time for the HEX display mux.
- Sits in the top level between the board keys and game logic on one side and the stopwatch instance on the other.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles (10 ms at 50 MHz) required before a key level is accepted.
- LIMIT_BCD, 16'h1000: time limit as packed BCD {tensMins, mins, tensSecs, secs}; 16'h0000 disables the limit.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start_key  in  1  raw start/restart key, active-high, asynchronous to clk
- pause_key  in  1  raw pause/resume key, active-high, asynchronous to clk
- solved  in  1  level from game logic; high when the grid is complete and correct
- time_bcd  in  16  stopwatch digits {tensMins, mins, tensSecs, secs}
- sw_run  out  1  stopwatch run enable
- sw_reset  out  1  stopwatch clear pulse
- state_o  out  3  current FSM state encoding
- timed_out  out  1  high while in TIMEOUT
- best_valid  out  1  best_bcd holds a recorded solve time
- best_bcd  out  16  fastest solve time since reset, packed BCD

Behaviour:
Reset and interface:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE (0); sw_run 0; sw_reset 0; timed_out 0; best_valid 0; best_bcd 16'h0000; synchronizers, debounce counters and debounced levels all 0.
- A reset asserted mid-operation returns the block to IDLE on the next edge and clears best_bcd and best_valid.

Key conditioning (per key):
- Two-flop synchronizer, then a counter that increments while the synchronized level differs from the debounced level and clears when they match.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Event = one-cycle pulse on each rising edge of the debounced level.
- Latency from a clean key rise to the event is DEBOUNCE_CYCLES+3 cycles.
- Holding a key produces exactly one event.

FSM (Moore outputs, decoded from registered state):
- IDLE=0, sw_run 0.
  - start_ev -> CLEAR.
- CLEAR=1, sw_reset 1 for exactly one cycle.
  - Always -> RUN.
- RUN=2, sw_run 1. Priority, highest first:
  1. solved -> SOLVED.
  2. LIMIT_BCD!=0 and time_bcd >= LIMIT_BCD -> TIMEOUT.
  3. start_ev -> CLEAR.
  4. pause_ev -> PAUSE.
- PAUSE=3, sw_run 0.
  - start_ev -> CLEAR; otherwise pause_ev -> RUN.
  - solved is ignored.
- SOLVED=4, sw_run 0.
  - start_ev -> CLEAR.
- TIMEOUT=5, timed_out 1.
  - start_ev -> CLEAR.
- Encodings 6 and 7 -> IDLE.

Datapath rules:
- sw_reset feeds the stopwatch's asynchronous reset, so it must come directly from a flop (a one-hot state bit or a registered decode) with no combinational glitch.
- Comparisons are 16-bit unsigned on packed BCD; this is valid because the digits are ordered MSB to LSB.
- Best-time update happens on the same edge as RUN->SOLVED, using time_bcd sampled that cycle:
  - if !best_valid or time_bcd < best_bcd: best_bcd <= time_bcd and best_valid <= 1;
  - an equal time leaves best_bcd unchanged.
- With the limit disabled, the stopwatch wraps 59:59 -> 00:00 with no timeout.
- start_ev and pause_ev in the same cycle: start_ev wins in every state.

Decomposition:
- Package timer_pkg holds:
  - state_t enum (IDLE, CLEAR, RUN, PAUSE, SOLVED, TIMEOUT) with fixed encodings 0-5;
  - BCD_W=16;
  - DEFAULT_LIMIT_BCD=16'h1000;
  - DEFAULT_DEBOUNCE=500000.
- Sub-module key_debounce (synchronizer, debounce counter, rising-edge pulse; parameter DEBOUNCE_CYCLES), instantiated once per key.

Test Plan (DEBOUNCE_CYCLES=4; bench drives time_bcd directly):
- Reset, then start_key held high 20 cycles -> single start_ev at cycle 7 after the rise; sw_reset high exactly 1 cycle; state_o=2 and sw_run=1 thereafter; no second event.
- start_key toggled every 2 cycles for 30 cycles, then low -> no event; state_o stays 0; sw_reset never asserts.
- Three solves:
  - RUN with time_bcd=16'h0104, solved=1 -> state_o=4, sw_run=0, best_bcd=16'h0104, best_valid=1;
  - restart, solve at 16'h0230 -> best_bcd stays 16'h0104;
  - restart, solve at 16'h0059 -> best_bcd=16'h0059.
- Limit behaviour:
  - RUN with time_bcd stepping 16'h0959 -> 16'h1000 -> state_o=5, timed_out=1, sw_run=0 on the next edge;
  - repeat with solved=1 in the same cycle as 16'h1000 -> state_o=4, best_bcd=16'h1000.
- Pause behaviour:
  - pause press in RUN -> state_o=3, sw_run=0;
  - solved=1 while in PAUSE -> no state change;
  - second pause press -> RUN;
  - start and pause pressed together in PAUSE -> CLEAR then RUN.
- Reset asserted in RUN with best_valid=1 -> next edge: state_o=0, sw_run=0, sw_reset=0, timed_out=0, best_valid=0, best_bcd=16'h0000.
